// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling datapath: byte type, S-array depth,
// and the state encodings of the populator and the KSA swapper.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        POP_IDLE,
        POP_WRITE,
        POP_DONE
    } pop_state_t;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_READ_I,
        KSA_WAIT_I,
        KSA_GET_I,
        KSA_READ_J,
        KSA_WAIT_J,
        KSA_GET_J,
        KSA_WR_I,
        KSA_WR_J,
        KSA_DONE
    } ksa_state_t;

endpackage

// File: rtl/rc4_ksa_swapper.sv
// RC4 key-scheduling loop over the shared S memory port: j += S[i] + key[i mod KEY_LEN],
// then swap S[i]/S[j]; 8 cycles per iteration, 256 iterations, one-cycle finish pulse.
module rc4_ksa_swapper
    import rc4_pkg::*;
#(
    parameter int KEY_LEN   = 3,
    parameter int MEM_DEPTH = rc4_pkg::MEM_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KEY_LEN*8-1:0] secret_key,
    input  logic [7:0]           q,
    output logic [7:0]           address,
    output logic [7:0]           data,
    output logic                 wren,
    output logic                 busy,
    output logic                 finish
);

    localparam byte_t LAST_I = byte_t'(MEM_DEPTH - 1);

    ksa_state_t state, state_nxt;
    byte_t      i, j, si, sj;
    byte_t      i_nxt, j_nxt, si_nxt, sj_nxt;
    byte_t      address_nxt, data_nxt;
    logic       wren_nxt, busy_nxt, finish_nxt;

    byte_t      key_idx, key_byte, j_upd;

    // Key byte 0 sits in the most significant byte of secret_key.
    assign key_idx = i % byte_t'(KEY_LEN);

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (key_idx == byte_t'(k)) key_byte = secret_key[(KEY_LEN-1-k)*8 +: 8];
        end
    end

    assign j_upd = j + q + key_byte;

    // Outputs are registered from the next state so they are stable for the
    // whole cycle the FSM spends in each state.
    always_comb begin
        state_nxt   = state;
        i_nxt       = i;
        j_nxt       = j;
        si_nxt      = si;
        sj_nxt      = sj;
        address_nxt = address;
        data_nxt    = data;
        wren_nxt    = 1'b0;
        busy_nxt    = 1'b0;
        finish_nxt  = 1'b0;

        case (state)
            KSA_IDLE: begin
                if (start) begin
                    i_nxt       = '0;
                    j_nxt       = '0;
                    address_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = KSA_READ_I;
                end
            end
            KSA_READ_I: begin
                busy_nxt  = 1'b1;
                state_nxt = KSA_WAIT_I;
            end
            KSA_WAIT_I: begin
                busy_nxt  = 1'b1;
                state_nxt = KSA_GET_I;
            end
            KSA_GET_I: begin
                si_nxt      = q;
                j_nxt       = j_upd;
                address_nxt = j_upd;
                busy_nxt    = 1'b1;
                state_nxt   = KSA_READ_J;
            end
            KSA_READ_J: begin
                busy_nxt  = 1'b1;
                state_nxt = KSA_WAIT_J;
            end
            KSA_WAIT_J: begin
                busy_nxt  = 1'b1;
                state_nxt = KSA_GET_J;
            end
            KSA_GET_J: begin
                sj_nxt      = q;
                address_nxt = i;
                data_nxt    = q;
                wren_nxt    = 1'b1;
                busy_nxt    = 1'b1;
                state_nxt   = KSA_WR_I;
            end
            KSA_WR_I: begin
                // Latched si is written back, so i==j rewrites the entry with itself.
                address_nxt = j;
                data_nxt    = si;
                wren_nxt    = 1'b1;
                busy_nxt    = 1'b1;
                state_nxt   = KSA_WR_J;
            end
            KSA_WR_J: begin
                if (i == LAST_I) begin
                    finish_nxt = 1'b1;
                    state_nxt  = KSA_DONE;
                end else begin
                    i_nxt       = i + 8'd1;
                    address_nxt = i + 8'd1;
                    busy_nxt    = 1'b1;
                    state_nxt   = KSA_READ_I;
                end
            end
            KSA_DONE: begin
                state_nxt = KSA_IDLE;
            end
            default: begin
                state_nxt = KSA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= KSA_IDLE;
            i       <= '0;
            j       <= '0;
            si      <= '0;
            sj      <= '0;
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state   <= state_nxt;
            i       <= i_nxt;
            j       <= j_nxt;
            si      <= si_nxt;
            sj      <= sj_nxt;
            address <= address_nxt;
            data    <= data_nxt;
            wren    <= wren_nxt;
            busy    <= busy_nxt;
            finish  <= finish_nxt;
        end
    end

endmodule

// File: tb/tb_rc4_ksa_swapper.sv
// Directed bench for rc4_ksa_swapper with a synchronous S-memory model and a software KSA reference.
module tb_rc4_ksa_swapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q;
    logic [7:0]  address, data;
    logic        wren, busy, finish;

    always #5 clk = ~clk;

    rc4_ksa_swapper #(.KEY_LEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .finish     (finish)
    );

    // Memory with registered address: q follows the address of the previous cycle.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        q <= mem[address];
        if (wren === 1'b1) mem[address] = data;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] wlog [$];
    always @(posedge clk) if (wren === 1'b1) wlog.push_back({address, data});

    int fin_cnt = 0;
    always @(negedge clk) if (finish === 1'b1) fin_cnt++;

    int errors = 0;
    int checks = 0;
    int t0 = 0;
    int fin_cyc = 0;

    logic [7:0]  ms [256];
    logic [15:0] mw [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_identity();
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'(k);
            ms[k]  = 8'(k);
        end
    endtask

    // Reference RC4 KSA on ms[], recording the expected (address,data) write pairs.
    task automatic model_ksa(input logic [23:0] key);
        logic [7:0] jj, si, sj, kb;
        jj = 8'd0;
        mw.delete();
        for (int ii = 0; ii < 256; ii++) begin
            kb = key[(2 - (ii % 3)) * 8 +: 8];
            jj = jj + ms[ii] + kb;
            si = ms[ii];
            sj = ms[jj];
            mw.push_back({8'(ii), sj});
            mw.push_back({jj, si});
            ms[ii] = sj;
            ms[jj] = si;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] key);
        secret_key = key;
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wlog.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(wlog.size() >= n), 32'd1);
    endtask

    task automatic wait_finish(input string tag, input int budget);
        int k = 0;
        while (finish !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        fin_cyc = cyc;
        check(tag, 32'(finish), 32'd1);
    endtask

    function automatic int log_mismatches();
        int bad = 0;
        if (wlog.size() != mw.size()) return 9999;
        for (int k = 0; k < mw.size(); k++) if (wlog[k] !== mw[k]) bad++;
        return bad;
    endfunction

    function automatic int mem_mismatches();
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ms[k]) bad++;
        return bad;
    endfunction

    initial begin
        load_identity();

        // Reset and idle behaviour
        tick(3);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data",    32'(data),    32'd0);
        check("rst_wren",    32'(wren),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_finish",  32'(finish),  32'd0);
        rst = 1'b0;
        wlog.delete();
        fin_cnt = 0;
        tick(20);
        check("idle_no_writes", 32'(wlog.size()), 32'd0);
        check("idle_no_finish", 32'(fin_cnt),     32'd0);
        check("idle_busy",      32'(busy),        32'd0);

        // Key 000000, identity S: two self-swaps then j=3 at i=2
        load_identity();
        wlog.delete();
        start_run(24'h000000);
        wait_writes("k0_writes", 6, 100);
        check("k0_w0", 32'(wlog[0]), 32'h0000);
        check("k0_w1", 32'(wlog[1]), 32'h0000);
        check("k0_w2", 32'(wlog[2]), 32'h0101);
        check("k0_w3", 32'(wlog[3]), 32'h0101);
        check("k0_w4", 32'(wlog[4]), 32'h0203);
        check("k0_w5", 32'(wlog[5]), 32'h0302);
        check("k0_busy", 32'(busy), 32'd1);
        do_reset(1);

        // Key 010203, identity S
        load_identity();
        wlog.delete();
        start_run(24'h010203);
        wait_writes("k1_writes", 4, 100);
        check("k1_w0", 32'(wlog[0]), 32'h0001);
        check("k1_w1", 32'(wlog[1]), 32'h0100);
        check("k1_w2", 32'(wlog[2]), 32'h0103);
        check("k1_w3", 32'(wlog[3]), 32'h0300);
        do_reset(1);

        // i==j at i=2: S[2]=1 makes j = 1 + 1 = 2
        load_identity();
        mem[2] = 8'd1;
        wlog.delete();
        start_run(24'h000000);
        wait_writes("ieqj_writes", 6, 100);
        check("ieqj_w4", 32'(wlog[4]), 32'h0201);
        check("ieqj_w5", 32'(wlog[5]), 32'h0201);
        check("ieqj_mem2", 32'(mem[2]), 32'd1);
        do_reset(1);

        // Full run, key 00033C, with stray start pulses at cycles 100 and 1500
        load_identity();
        model_ksa(24'h00033C);
        wlog.delete();
        fin_cnt = 0;
        start_run(24'h00033C);
        tick(99);
        check("pulse100_busy", 32'(busy), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1500 - (cyc - t0));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_finish("full_finish_seen", 1000);
        check("full_latency", 32'(fin_cyc - t0), 32'd2049);
        tick(5);
        check("full_finish_once", 32'(fin_cnt), 32'd1);
        check("full_write_count", 32'(wlog.size()), 32'd512);
        check("full_write_seq", 32'(log_mismatches()), 32'd0);
        check("full_final_s", 32'(mem_mismatches()), 32'd0);
        check("full_idle_busy", 32'(busy), 32'd0);

        // Reset mid-run at cycle 1000, then a fresh run completes normally
        load_identity();
        wlog.delete();
        start_run(24'h010203);
        tick(999);
        do_reset(1);
        check("midrst_wren",    32'(wren),    32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_address", 32'(address), 32'd0);
        check("midrst_finish",  32'(finish),  32'd0);
        wlog.delete();
        tick(10);
        check("midrst_quiet", 32'(wlog.size()), 32'd0);
        load_identity();
        model_ksa(24'h010203);
        wlog.delete();
        fin_cnt = 0;
        start_run(24'h010203);
        wait_finish("rerun_finish_seen", 2100);
        check("rerun_latency", 32'(fin_cyc - t0), 32'd2049);
        check("rerun_write_seq", 32'(log_mismatches()), 32'd0);
        check("rerun_final_s", 32'(mem_mismatches()), 32'd0);

        // start held high across finish restarts from IDLE
        load_identity();
        secret_key = 24'h000000;
        start = 1'b1;
        wait_finish("held_finish_seen", 2100);
        tick(1);
        check("held_idle_busy", 32'(busy), 32'd0);
        tick(1);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        do_reset(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
